// File: rtl/verlet_pkg.sv
// Shared types and helpers for the Verlet particle node.
package verlet_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    // Axis counter width: $clog2(n), never below one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Saturate a signed value to the signed range of 'width' bits.
    function automatic logic signed [63:0] sat_w(input logic signed [63:0] value,
                                                 input int unsigned width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi)
            return hi;
        else if (value < lo)
            return lo;
        return value;
    endfunction

endpackage

// File: rtl/verlet_axis_alu.sv
// Combinational single-axis Verlet update with saturation and boundary clamp.
// Define VERLET_DAMPING_EN to select the damped update formula.
module verlet_axis_alu
    import verlet_pkg::*;
#(
    parameter int W          = 16,
    parameter int BOUND_MIN  = -1000,
    parameter int BOUND_MAX  = 1000,
    parameter int DAMP_SHIFT = 4
) (
    input  logic signed [W-1:0] x,
    input  logic signed [W-1:0] px,
    input  logic signed [W-1:0] a,
    output logic signed [W-1:0] x_new,
    output logic signed [W-1:0] vel,
    output logic                clamped
);

    logic signed [W+1:0] x2, px2, a2, t;
    logic signed [W:0]   x1, xn1;
    logic signed [63:0]  s, v;
`ifdef VERLET_DAMPING_EN
    logic signed [W:0]   d;
    logic signed [W:0]   d_sh;
`endif

    always_comb begin
        x2  = $signed({{2{x[W-1]}}, x});
        px2 = $signed({{2{px[W-1]}}, px});
        a2  = $signed({{2{a[W-1]}}, a});
`ifdef VERLET_DAMPING_EN
        d    = $signed({x[W-1], x}) - $signed({px[W-1], px});
        d_sh = d >>> DAMP_SHIFT;
        t    = x2 + $signed({d[W], d}) - $signed({d_sh[W], d_sh}) + a2;
`else
        t    = x2 + x2 - px2 + a2;
`endif
        s       = sat_w(64'(t), W);
        clamped = 1'b0;
        if (s > 64'(BOUND_MAX)) begin
            s       = 64'(BOUND_MAX);
            clamped = 1'b1;
        end else if (s < 64'(BOUND_MIN)) begin
            s       = 64'(BOUND_MIN);
            clamped = 1'b1;
        end
        x_new = s[W-1:0];

        x1    = $signed({x[W-1], x});
        xn1   = $signed({x_new[W-1], x_new});
        v     = sat_w(64'(xn1 - x1), W);
        vel   = v[W-1:0];
    end

endmodule

// File: rtl/verlet_particle.sv
// Multi-axis position-Verlet particle node: serial axis ALU, atomic commit.
// Optional damping via VERLET_DAMPING_EN (handled inside verlet_axis_alu).
module verlet_particle
    import verlet_pkg::*;
#(
    parameter int          W          = 16,
    parameter int unsigned N_DIM      = 2,
    parameter int          BOUND_MIN  = -1000,
    parameter int          BOUND_MAX  = 1000,
    parameter int          DAMP_SHIFT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [N_DIM*W-1:0] load_pos,
    input  logic               step_valid,
    output logic               step_ready,
    input  logic [N_DIM*W-1:0] accel,
    output logic [N_DIM*W-1:0] pos_out,
    output logic [N_DIM*W-1:0] vel_out,
    output logic               done
);

    localparam int unsigned    CW   = cnt_w(N_DIM);
    localparam logic [CW-1:0]  LAST = CW'(N_DIM - 1);

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic          handshake;

    logic signed [W-1:0] x_q   [N_DIM];
    logic signed [W-1:0] px_q  [N_DIM];
    logic signed [W-1:0] acc_q [N_DIM];
    logic signed [W-1:0] xw    [N_DIM];
    logic signed [W-1:0] pxw   [N_DIM];
    logic signed [W-1:0] vw    [N_DIM];

    logic signed [W-1:0] alu_x_new, alu_vel;
    logic                alu_clamped;

    verlet_axis_alu #(
        .W         (W),
        .BOUND_MIN (BOUND_MIN),
        .BOUND_MAX (BOUND_MAX),
        .DAMP_SHIFT(DAMP_SHIFT)
    ) u_alu (
        .x      (x_q[cnt]),
        .px     (px_q[cnt]),
        .a      (acc_q[cnt]),
        .x_new  (alu_x_new),
        .vel    (alu_vel),
        .clamped(alu_clamped)
    );

    always_comb begin
        step_ready = (state == IDLE) && !load;
        handshake  = step_valid && step_ready;
        state_nx   = state;
        case (state)
            IDLE:    if (handshake) state_nx = CALC;
            CALC:    if (cnt == LAST) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            done    <= 1'b0;
            pos_out <= '0;
            vel_out <= '0;
            for (int unsigned k = 0; k < N_DIM; k++) begin
                x_q[k]   <= '0;
                px_q[k]  <= '0;
                acc_q[k] <= '0;
                xw[k]    <= '0;
                pxw[k]   <= '0;
                vw[k]    <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        pos_out <= load_pos;
                        vel_out <= '0;
                        for (int unsigned k = 0; k < N_DIM; k++) begin
                            x_q[k]  <= load_pos[k*W +: W];
                            px_q[k] <= load_pos[k*W +: W];
                        end
                    end else if (handshake) begin
                        for (int unsigned k = 0; k < N_DIM; k++)
                            acc_q[k] <= accel[k*W +: W];
                    end
                end
                CALC: begin
                    // A clamped axis keeps px equal to its new x so velocity dies there.
                    xw[cnt]  <= alu_x_new;
                    pxw[cnt] <= alu_clamped ? alu_x_new : x_q[cnt];
                    vw[cnt]  <= alu_vel;
                    cnt      <= (cnt == LAST) ? '0 : cnt + 1'b1;
                end
                DONE: begin
                    done <= 1'b1;
                    for (int unsigned k = 0; k < N_DIM; k++) begin
                        x_q[k]             <= xw[k];
                        px_q[k]            <= pxw[k];
                        pos_out[k*W +: W]  <= xw[k];
                        vel_out[k*W +: W]  <= vw[k];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_verlet_particle.sv
// Scoreboard bench for verlet_particle (W=16, N_DIM=2, DAMP_SHIFT=2).
module tb_verlet_particle;

    localparam int W = 16;
    localparam int N = 2;

    logic         clk = 1'b0;
    logic         rst, load, step_valid, step_ready, done;
    logic [N*W-1:0] load_pos, accel, pos_out, vel_out;

    always #5 clk = ~clk;

    verlet_particle #(
        .W         (W),
        .N_DIM     (N),
        .BOUND_MIN (-1000),
        .BOUND_MAX (1000),
        .DAMP_SHIFT(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_pos  (load_pos),
        .step_valid(step_valid),
        .step_ready(step_ready),
        .accel     (accel),
        .pos_out   (pos_out),
        .vel_out   (vel_out),
        .done      (done)
    );

    typedef struct packed {
        logic [31:0] pos;
        logic [31:0] vel;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;

    function automatic logic [31:0] pk(input int a, input int b);
        return {b[15:0], a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expected commit.
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done actual=1 required=0 pos=%h", pos_out);
            end else begin
                me = q.pop_front();
                chk("commit_pos", pos_out, me.pos);
                chk("commit_vel", vel_out, me.vel);
            end
        end
    end

    task automatic do_load(input int a, input int b);
        load     = 1'b1;
        load_pos = pk(a, b);
        @(posedge clk); #1;
        load = 1'b0;
        chk("load_pos", pos_out, pk(a, b));
        chk("load_vel", vel_out, 32'h0);
    endtask

    task automatic do_step(input logic [31:0] a, input logic [31:0] xp,
                           input logic [31:0] vp, input bit mid_load);
        int lat;
        int i;
        q.push_back('{pos: xp, vel: vp});
        i = 0;
        while (!step_ready && i < 20) begin
            @(posedge clk); #1;
            i++;
        end
        step_valid = 1'b1;
        accel      = a;
        @(posedge clk); #1;
        step_valid = 1'b0;
        accel      = '0;
        if (mid_load) begin
            load     = 1'b1;
            load_pos = pk(500, 500);
        end
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            load = 1'b0;
            if (done) begin
                lat = k;
                break;
            end
        end
        chk("latency", 32'(lat), 32'd3);
        @(negedge clk); #1;
    endtask

    int d0;

    initial begin
        rst = 1'b1; load = 1'b0; step_valid = 1'b0; accel = '0; load_pos = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_pos", pos_out, 32'h0);
        chk("rst_vel", vel_out, 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_ready", 32'(step_ready), 32'h1);

        do_load(100, -50);
        do_step(pk(0, 0), pk(100, -50), pk(0, 0), 1'b0);

        do_load(0, 0);
        do_step(pk(2, 0), pk(2, 0),  pk(2, 0), 1'b0);
        do_step(pk(2, 0), pk(6, 0),  pk(4, 0), 1'b0);
        do_step(pk(2, 0), pk(12, 0), pk(6, 0), 1'b0);
`ifdef VERLET_DAMPING_EN
        do_step(pk(0, 0), pk(17, 0), pk(5, 0), 1'b0);
`else
        do_step(pk(0, 0), pk(18, 0), pk(6, 0), 1'b0);
`endif

        do_load(990, 0);
        do_step(pk(20, 0), pk(1000, 0), pk(10, 0), 1'b0);
        do_step(pk(0, 0),  pk(1000, 0), pk(0, 0),  1'b0);

        // load during CALC must not disturb the step or the stored state
        do_load(10, 20);
        do_step(pk(3, -4), pk(13, 16), pk(3, -4), 1'b1);
        chk("post_midload_pos", pos_out, pk(13, 16));
        do_step(pk(0, 0), pk(16, 12), pk(3, -4), 1'b0);

        // load and step together: load wins
        load = 1'b1; step_valid = 1'b1; load_pos = pk(7, 8); accel = pk(9, 9);
        #1;
        chk("load_step_ready", 32'(step_ready), 32'h0);
        d0 = done_cnt;
        @(posedge clk); #1;
        load = 1'b0; step_valid = 1'b0; accel = '0;
        chk("load_step_pos", pos_out, pk(7, 8));
        repeat (5) @(posedge clk);
        #1;
        chk("load_step_nodone", 32'(done_cnt), 32'(d0));

        // reset during CALC aborts without commit
        d0 = done_cnt;
        step_valid = 1'b1; accel = pk(1, 1);
        @(posedge clk); #1;
        step_valid = 1'b0; accel = '0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_pos", pos_out, 32'h0);
        chk("midrst_vel", vel_out, 32'h0);
        chk("midrst_done", 32'(done), 32'h0);
        chk("midrst_ready", 32'(step_ready), 32'h1);
        repeat (5) @(posedge clk);
        #1;
        chk("midrst_nodone", 32'(done_cnt), 32'(d0));
        do_step(pk(4, 0), pk(4, 0), pk(4, 0), 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/verlet_particle.md
Name: verlet_particle

Overview:
- Parametrised successor to the single-particle node. Holds position and previous position for N_DIM axes and performs one position-Verlet step per accepted request: x_new = 2x - px + a.
- Adds a valid/ready step handshake, an explicit load interface, saturating fixed-point arithmetic and per-axis boundary clamping.
- Axes are processed serially through one shared axis ALU.
- Sits in the particle array; a scheduler drives step requests, and outputs feed the constraint/render stages.

Parameters:
- W, 16, signed two's-complement width of position, acceleration and velocity.
- N_DIM, 2, number of spatial axes (1..8).
- BOUND_MIN, -1000, lower clamp bound, all axes (signed W).
- BOUND_MAX, 1000, upper clamp bound, all axes; must satisfy BOUND_MIN < BOUND_MAX.
- DAMP_SHIFT, 4, damping shift; used only with VERLET_DAMPING_EN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- load  in  1  load pulse: sets x = px = load_pos
- load_pos  in  N_DIM*W  initial position, axis 0 in LSBs
- step_valid  in  1  step request
- step_ready  out  1  step can be accepted this cycle
- accel  in  N_DIM*W  pre-scaled a*dt^2 per axis; sampled on handshake
- pos_out  out  N_DIM*W  committed position
- vel_out  out  N_DIM*W  committed velocity (x_new - x_old)
- done  out  1  one-cycle pulse when a step commits

Behaviour:
- Reset (synchronous, active-high):
  - All x, px, pos_out and vel_out registers go to 0.
  - FSM goes to IDLE, done=0, axis counter=0.
  - Reset asserted during CALC aborts the step with no partial commit.
- FSM states:
  - IDLE -> CALC on step handshake (step_valid && step_ready). accel is captured into a shadow register at handshake.
  - CALC lasts N_DIM cycles. Each cycle processes axis k = counter and writes x_new[k] / vel[k] into working registers. Counter wraps 0..N_DIM-1; after the last axis the FSM goes to DONE.
  - DONE lasts 1 cycle:
    - px <= x_old and x <= x_new for all axes atomically.
    - pos_out and vel_out update at the same edge; done=1.
    - FSM returns to IDLE.
- Timing:
  - step_ready = (state==IDLE) && !load.
  - Handshake at edge t gives done high in cycle t+N_DIM+1 (i.e. N_DIM+1 cycles after the handshake).
  - pos_out and vel_out never show partial (per-axis) updates.
- Load:
  - Honoured only in IDLE; x and px are set to load_pos.
  - pos_out <= load_pos and vel_out <= 0 at the next edge; done is not pulsed.
  - load outside IDLE is ignored (not queued).
  - load and step_valid in the same IDLE cycle: load wins and the step is not accepted.
- Axis arithmetic:
  - Computed in W+2 bits: t = 2x - px + a.
  - Result saturates to the signed-W range, then clamps to [BOUND_MIN, BOUND_MAX].
  - If the clamp engaged on an axis, px for that axis is written as the clamped value (velocity killed), not x_old.
  - vel = x_new - x_old computed in W+1 bits and saturated to W.
- step_valid held high across CALC/DONE is not accepted until the FSM returns to IDLE.

Optional Feature:
- Macro: VERLET_DAMPING_EN.
- When defined: t = x + d - (d >>> DAMP_SHIFT) + a, where d = x - px and >>> is an arithmetic shift. Saturation and clamp rules are unchanged.
- When undefined: undamped formula; DAMP_SHIFT has no effect.
- Latency is identical in both builds.

Decomposition:
- Package verlet_pkg holds:
  - FSM state enum (IDLE, CALC, DONE).
  - Signed saturate function sat_w(value, width).
  - Counter width constant $clog2(N_DIM) with a minimum of 1.
- One natural sub-module, verlet_axis_alu: combinational single-axis update.
  - Inputs: x, px, a.
  - Outputs: x_new, vel, clamped flag.
  - Contains the damping ifdef.
- Top level holds the FSM, axis counter, working/shadow registers and the handshake.

Test Plan (W=16, N_DIM=2, defaults):
- Reset: assert rst 2 cycles -> pos_out=0, vel_out=0, done=0, step_ready=1.
- Load (100,-50), then step with accel (0,0) -> done in cycle t+3; pos_out=(100,-50); vel_out=(0,0).
- Load (0,0), three steps with accel (2,0):
  - pos_out x = 2, 6, 12; vel_out x = 2, 4, 6; y stays 0.
  - Then one step with accel 0 -> x=18, vel 6 (undamped).
  - Same step with VERLET_DAMPING_EN and DAMP_SHIFT=2 -> x=17, vel 5.
- Load (990,0), step with accel (20,0) -> x=1000 (clamped), vel_out x=10. Next step with accel 0 -> x stays 1000, vel 0.
- Handshake edge cases:
  - load during CALC is ignored; the step commits the pre-load values.
  - load+step_valid together in IDLE -> load applied, step_ready=0, no done.
- Mid-operation reset: rst asserted in the CALC cycle after a handshake -> no done pulse; pos_out=0 next cycle; FSM back in IDLE.
